// File: rtl/sparse_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sparse_loader_pkg
// Description : Shared definitions for the sparse position loader: controller
//               state encoding, default padding / range-limit values and the
//               half-word field positions inside a packed sparse word.
// Revision    : 1.0 - initial release
// ============================================================================
package sparse_loader_pkg;

    // Controller states.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GET_HIGH = 3'd1,
        GET_LOW  = 3'd2,
        WRITE    = 3'd3,
        FILL     = 3'd4,
        DONE     = 3'd5
    } state_e;

    localparam logic [15:0] PAD_POS_DEFAULT = 16'hFFFF;
    localparam int unsigned POS_MAX_DEFAULT = 17669;

    // Packed word layout: {high[31:16], low[15:0]}.
    localparam int HIGH_MSB = 31;
    localparam int HIGH_LSB = 16;
    localparam int LOW_MSB  = 15;
    localparam int LOW_LSB  = 0;

endpackage : sparse_loader_pkg
`default_nettype wire

// File: rtl/sparse_loader.sv
`default_nettype none
// ============================================================================
// Module      : sparse_loader
// Description : Collects a stream of 16-bit sparse positions, packs them in
//               pairs into {high, low} words and writes them to a sparse
//               memory of MEM_SPARSE_SIZE words. A stream ended early with
//               pos_last is padded with PAD_POS up to the end of the memory.
//               Optional feature macro: SPARSE_LOADER_RANGE_CHECK_EN enables
//               a sticky flag for accepted positions >= POS_MAX.
// Ports       : clk, rst (sync, active-high)
//               start_load            - one-cycle load request (IDLE only)
//               pos_data/valid/last   - position stream, pos_ready handshake
//               sparse_mem_write_*    - write strobe, packed data, address
//               busy, load_done       - load in progress / completion pulse
//               range_err             - sticky out-of-range flag
// Revision    : 1.0 - initial release
// ============================================================================
module sparse_loader
    import sparse_loader_pkg::*;
#(
    parameter int unsigned WORD_WIDTH      = 32,
    parameter int unsigned MEM_SPARSE_SIZE = 50,
    parameter int unsigned POS_MAX         = POS_MAX_DEFAULT,
    parameter logic [15:0] PAD_POS         = PAD_POS_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_load,
    input  logic [15:0]           pos_data,
    input  logic                  pos_valid,
    input  logic                  pos_last,
    output logic                  pos_ready,
    output logic [WORD_WIDTH-1:0] sparse_mem_write_data,
    output logic                  sparse_mem_write_en,
    output logic [9:0]            sparse_mem_addr_o,
    output logic                  busy,
    output logic                  load_done,
    output logic                  range_err
);

    state_e      state_q, state_d;
    logic [9:0]  idx_q, idx_d;
    logic [15:0] high_q, high_d;
    logic [15:0] low_q, low_d;
    logic        last_q, last_d;   // pos_last has been accepted in this load

    logic        w_xfer;
    logic [9:0]  w_idx_inc;
    logic        w_idx_end;
    logic [31:0] w_word;

    assign w_xfer    = pos_valid && pos_ready;
    assign w_idx_inc = idx_q + 10'd1;
    assign w_idx_end = (w_idx_inc == 10'(MEM_SPARSE_SIZE));

    // Next-state and datapath updates.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        high_d  = high_q;
        low_d   = low_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (start_load) begin
                    state_d = GET_HIGH;
                    idx_d   = '0;
                    last_d  = 1'b0;
                end
            end
            GET_HIGH: begin
                if (w_xfer) begin
                    high_d = pos_data;
                    if (pos_last) begin
                        // Odd-length stream: the missing low half is padding.
                        low_d   = PAD_POS;
                        last_d  = 1'b1;
                        state_d = WRITE;
                    end else begin
                        state_d = GET_LOW;
                    end
                end
            end
            GET_LOW: begin
                if (w_xfer) begin
                    low_d   = pos_data;
                    last_d  = pos_last;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                idx_d = w_idx_inc;
                if (w_idx_end) begin
                    state_d = DONE;
                end else if (last_q) begin
                    state_d = FILL;
                end else begin
                    state_d = GET_HIGH;
                end
            end
            FILL: begin
                idx_d = w_idx_inc;
                if (w_idx_end) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the state so reset alone forces them to zero.
    always_comb begin
        w_word = '0;
        if (state_q == WRITE) begin
            w_word[HIGH_MSB:HIGH_LSB] = high_q;
            w_word[LOW_MSB:LOW_LSB]   = low_q;
        end else if (state_q == FILL) begin
            w_word[HIGH_MSB:HIGH_LSB] = PAD_POS;
            w_word[LOW_MSB:LOW_LSB]   = PAD_POS;
        end
    end

    assign pos_ready             = (state_q == GET_HIGH) || (state_q == GET_LOW);
    assign sparse_mem_write_en   = (state_q == WRITE) || (state_q == FILL);
    assign sparse_mem_write_data = WORD_WIDTH'(w_word);
    assign sparse_mem_addr_o     = sparse_mem_write_en ? idx_q : 10'd0;
    assign busy                  = (state_q != IDLE) && (state_q != DONE);
    assign load_done             = (state_q == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            high_q  <= '0;
            low_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            high_q  <= high_d;
            low_q   <= low_d;
            last_q  <= last_d;
        end
    end

`ifdef SPARSE_LOADER_RANGE_CHECK_EN
    logic range_err_q, range_err_d;

    // Sticky until the next accepted start_load; the value itself is still
    // written unchanged.
    always_comb begin
        range_err_d = range_err_q;
        if ((state_q == IDLE) && start_load) begin
            range_err_d = 1'b0;
        end else if (w_xfer && (32'(pos_data) >= POS_MAX)) begin
            range_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            range_err_q <= 1'b0;
        end else begin
            range_err_q <= range_err_d;
        end
    end

    assign range_err = range_err_q;
`else
    logic [31:0] w_unused_pos_max;
    assign w_unused_pos_max = 32'(POS_MAX);
    assign range_err        = 1'b0;
`endif

endmodule : sparse_loader
`default_nettype wire
